// File: rtl/serial_seq_gen.sv
// rtl/serial_seq_gen.sv - MSB-first serial pattern generator with repeats, idle gaps, start/busy/done and abort
// Optional loopback "001" detector on the serial output: define SERIAL_SEQ_GEN_LOOPBACK_EN
module serial_seq_gen #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4,
  parameter int GAP   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIDTH-1:0]           pattern,
  input  logic [$clog2(WIDTH+1)-1:0] len,
  input  logic [REP_W-1:0]           reps,
  output logic                       out_bit,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 match_cnt
);

  localparam int            LW      = $clog2(WIDTH+1);
  localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);
  localparam logic [3:0]    GAP_LEN = 4'(GAP);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;     // captured pattern, left-aligned so the first bit sits at the MSB
  logic [WIDTH-1:0] shreg;     // working copy shifted left once per sent bit
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    bit_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic [3:0]       gap_cnt;

  logic [LW-1:0]    eff_len;
  logic [REP_W-1:0] eff_reps;
  logic [WIDTH-1:0] aligned;
  logic             accept;

  // Normalise len/reps and left-align the active field of the pattern
  always_comb begin
    eff_len = len;
    if (len == '0 || len > LEN_MAX) eff_len = LEN_MAX;
    eff_reps = reps;
    if (reps == '0) eff_reps = REP_W'(1);
    aligned = pattern << (LEN_MAX - eff_len);
    accept  = (state == ST_IDLE) && start && !abort;
  end

  // Transmit FSM; outputs are registered and reflect the state held during the previous cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pat_q     <= '0;
      shreg     <= '0;
      len_q     <= '0;
      bit_cnt   <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          if (accept) begin
            pat_q   <= aligned;
            shreg   <= aligned;
            len_q   <= eff_len;
            bit_cnt <= eff_len - 1'b1;
            rep_cnt <= eff_reps;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            out_bit   <= shreg[WIDTH-1];
            out_valid <= 1'b1;
            busy      <= 1'b1;
            shreg     <= shreg << 1;
            if (bit_cnt == '0) begin
              if (rep_cnt == REP_W'(1)) begin
                state <= ST_DONE;
              end else begin
                // Reload for the next repetition; with no gap the next first bit follows directly
                rep_cnt <= rep_cnt - 1'b1;
                shreg   <= pat_q;
                bit_cnt <= len_q - 1'b1;
                if (GAP_LEN != 4'd0) begin
                  gap_cnt <= GAP_LEN;
                  state   <= ST_GAP;
                end
              end
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        ST_GAP: begin
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            busy    <= 1'b1;
            gap_cnt <= gap_cnt - 4'd1;
            if (gap_cnt == 4'd1) state <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_SEQ_GEN_LOOPBACK_EN
  typedef enum logic [1:0] {DET_NONE, DET_0, DET_00} det_t;

  det_t       det;
  logic [7:0] hits;

  // Overlapping Mealy "001" detector on the registered serial output; idle/gap cycles leave it untouched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det  <= DET_NONE;
      hits <= 8'd0;
    end else if (accept) begin
      det  <= DET_NONE;
      hits <= 8'd0;
    end else if (out_valid) begin
      case (det)
        DET_NONE: det <= out_bit ? DET_NONE : DET_0;
        DET_0:    det <= out_bit ? DET_NONE : DET_00;
        DET_00: begin
          if (out_bit) begin
            det <= DET_NONE;
            if (hits != 8'hFF) hits <= hits + 8'd1;
          end else begin
            det <= DET_00;
          end
        end
        default: det <= DET_NONE;
      endcase
    end
  end

  assign match_cnt = hits;
`else
  assign match_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_serial_seq_gen.sv
// tb/tb_serial_seq_gen.sv - scoreboard bench for serial_seq_gen, GAP=0 and GAP=2 instances in parallel
module tb_serial_seq_gen;

  localparam int WIDTH = 8;
  localparam int REP_W = 4;
  localparam int LW    = $clog2(WIDTH+1);

  typedef struct {
    bit is_done;
    bit val;
    int cyc;
    int busy_len;
    int mcnt;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic [REP_W-1:0] reps;
  logic             ob [2];
  logic             ov [2];
  logic             by [2];
  logic             dn [2];
  logic [7:0]       mc [2];

  ev_t q0[$];
  ev_t q1[$];
  int  cyc   = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  run_len [2];
  bit  done_seen [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_seq_gen #(.WIDTH(WIDTH), .REP_W(REP_W), .GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .reps(reps),
    .out_bit(ob[0]), .out_valid(ov[0]), .busy(by[0]), .done(dn[0]), .match_cnt(mc[0])
  );

  serial_seq_gen #(.WIDTH(WIDTH), .REP_W(REP_W), .GAP(2)) u_g2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .reps(reps),
    .out_bit(ob[1]), .out_valid(ov[1]), .busy(by[1]), .done(dn[1]), .match_cnt(mc[1])
  );

  task automatic chk(input string name, input int g, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s[gap%0d] @cyc %0d: actual %0d required %0d", name, 2*g, cyc, act, req);
    end
  endtask

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_ev(input int g, input ev_t e);
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic pop_ev(input int g, output ev_t e);
    if (g == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  // Monitor: pops the scoreboard whenever an instance presents a bit or a done pulse
  task automatic mon(input int g);
    ev_t e;
    if (reset !== 1'b1) begin
      run_len[g] = 0;
      return;
    end
    if (ov[g] === 1'b1) begin
      if (qsize(g) == 0) chk("unexpected_bit", g, 1, 0);
      else begin
        pop_ev(g, e);
        chk("bit_kind", g, int'(e.is_done), 0);
        chk("bit_cycle", g, cyc, e.cyc);
        chk("bit_value", g, int'(ob[g]), int'(e.val));
        chk("busy_with_bit", g, int'(by[g]), 1);
      end
    end else begin
      chk("bit_zero_when_invalid", g, int'(ob[g]), 0);
    end
    if (dn[g] === 1'b1) begin
      done_seen[g] = 1'b1;
      if (qsize(g) == 0) chk("unexpected_done", g, 1, 0);
      else begin
        pop_ev(g, e);
        chk("done_kind", g, int'(e.is_done), 1);
        chk("done_cycle", g, cyc, e.cyc);
        chk("busy_at_done", g, int'(by[g]), 0);
        chk("busy_cycles", g, run_len[g], e.busy_len);
        chk("match_cnt", g, int'(mc[g]), e.mcnt);
      end
    end
    if (by[g] === 1'b1) run_len[g]++;
    else                run_len[g] = 0;
  endtask

  always begin
    @(posedge clk);
    #1;
    mon(0);
    mon(1);
  end

  // One transmission; called just after a negedge. stop_k>0 cuts it after bit stop_k by abort or reset.
  task automatic run(input logic [7:0] pat, input int ln, input int rp,
                     input int stop_k, input bit use_rst, input bit hold);
    int  el, er, n, t, cnt, idx, gp;
    bit  s[$];
    ev_t e;
    el = (ln == 0 || ln > WIDTH) ? WIDTH : ln;
    er = (rp == 0) ? 1 : rp;
    pattern = pat;
    len     = LW'(ln);
    reps    = REP_W'(rp);
    start   = 1'b1;
    abort   = 1'b0;
    n = cyc + 1;
    for (int r = 0; r < er; r++)
      for (int i = 0; i < el; i++) s.push_back(pat[el-1-i]);
    cnt = 0;
    for (int i = 2; i < s.size(); i++)
      if (!s[i-2] && !s[i-1] && s[i]) cnt++;
    if (cnt > 255) cnt = 255;
`ifndef SERIAL_SEQ_GEN_LOOPBACK_EN
    cnt = 0;
`endif
    for (int g = 0; g < 2; g++) begin
      gp = 2 * g;
      done_seen[g] = 1'b0;
      for (int r = 0; r < er; r++) begin
        for (int i = 0; i < el; i++) begin
          idx = r * el + i;
          if (stop_k == 0 || idx < stop_k) begin
            e.is_done  = 1'b0;
            e.val      = s[idx];
            e.cyc      = n + 1 + r * (el + gp) + i;
            e.busy_len = 0;
            e.mcnt     = 0;
            push_ev(g, e);
          end
        end
      end
      if (stop_k == 0) begin
        e.is_done  = 1'b1;
        e.val      = 1'b0;
        e.cyc      = n + 1 + er * el + (er - 1) * gp;
        e.busy_len = er * el + (er - 1) * gp;
        e.mcnt     = cnt;
        push_ev(g, e);
      end
    end
    @(negedge clk);
    if (!hold) begin
      start   = 1'b0;
      pattern = WIDTH'($urandom);
      len     = LW'($urandom);
      reps    = REP_W'($urandom);
    end
    if (stop_k > 0) begin
      while (cyc < n + stop_k) @(negedge clk);
      if (use_rst) begin
        #2 reset = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
          chk("rst_out_valid", g, int'(ov[g]), 0);
          chk("rst_busy", g, int'(by[g]), 0);
          chk("rst_out_bit", g, int'(ob[g]), 0);
          chk("rst_match_cnt", g, int'(mc[g]), 0);
        end
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset = 1'b1;
      end else begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int g = 0; g < 2; g++) begin
          chk("abort_out_valid", g, int'(ov[g]), 0);
          chk("abort_busy", g, int'(by[g]), 0);
        end
      end
      repeat (4) @(negedge clk);
      for (int g = 0; g < 2; g++) chk("no_done_after_stop", g, int'(done_seen[g]), 0);
    end else begin
      t = 0;
      while (!(done_seen[0] && done_seen[1]) && t < 4000) begin
        @(negedge clk);
        t++;
      end
      chk("done_timeout", 0, int'(t < 4000), 1);
    end
  endtask

  initial begin
    logic [7:0] pat;
    int ln, rp, el, er, sk, mode;
    bit hold;
    run_len[0] = 0; run_len[1] = 0;
    done_seen[0] = 1'b0; done_seen[1] = 1'b0;
    reset = 1'b0; start = 1'b1; abort = 1'b0;
    pattern = 8'hFF; len = '0; reps = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_out_bit", g, int'(ob[g]), 0);
      chk("reset_out_valid", g, int'(ov[g]), 0);
      chk("reset_busy", g, int'(by[g]), 0);
      chk("reset_done", g, int'(dn[g]), 0);
      chk("reset_match_cnt", g, int'(mc[g]), 0);
    end
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) chk("idle_after_reset", g, int'(by[g]), 0);

    run(8'h13, 7, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    run(8'h05, 3, 3, 0, 0, 0);
    repeat (2) @(negedge clk);
    run(8'hA5, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    run(8'hC3, 8, 1, 3, 0, 0);
    run(8'h5A, 8, 1, 0, 0, 0);
    repeat (1) @(negedge clk);
    run(8'h6B, 5, 1, 0, 0, 1);
    run(8'h09, 4, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    run(8'h01, 1, 4, 0, 0, 0);
    repeat (2) @(negedge clk);
    run(8'h96, 8, 15, 0, 0, 0);
    repeat (2) @(negedge clk);
    run(8'h3C, 12, 2, 0, 0, 0);
    repeat (2) @(negedge clk);
    run(8'h24, 8, 2, 5, 1, 0);
    repeat (2) @(negedge clk);
    run(8'h49, 8, 2, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      pat  = 8'($urandom);
      ln   = $urandom_range(0, 15);
      rp   = $urandom_range(0, 15);
      el   = (ln == 0 || ln > WIDTH) ? WIDTH : ln;
      er   = (rp == 0) ? 1 : rp;
      sk   = 0;
      hold = 1'b0;
      mode = $urandom_range(0, 5);
      if (mode == 0 && (er > 1 || el > 1)) sk = $urandom_range(1, (er > 1) ? el : el - 1);
      else if (mode == 1 && er == 1) hold = 1'b1;
      run(pat, ln, rp, sk, 1'b0, hold);
      if (!hold) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("queue_empty", 0, qsize(0), 0);
    chk("queue_empty", 1, qsize(1), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
